// File: rtl/car_geom_pkg.sv
// Shared geometry constants, quad sign table and FSM state type for the car vertex generator.
package car_geom_pkg;

   localparam int TRIG_FRAC  = 14;
   localparam int TRIG_W     = 16;
   localparam int ROUND_HALF = 1 << (TRIG_FRAC - 1);

   localparam int BODY_HX  = 100;
   localparam int BODY_HY  = 50;
   localparam int WHEEL_OX = 100;   // wheel centres sit at (-/+WHEEL_OX, WHEEL_OY)
   localparam int WHEEL_OY = -50;
   localparam int WHEEL_H  = 25;

   // Bit v set means positive offset; vertex order (-,-) (-,+) (+,+) (+,-).
   localparam logic [3:0] QUAD_SX = 4'b1100;
   localparam logic [3:0] QUAD_SY = 4'b0110;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRIG,
      ST_BODY,
      ST_WCTR,
      ST_WHEEL,
      ST_COMMIT
   } state_e;

   function automatic int sgn_mag(input logic pos, input int mag);
      return pos ? mag : -mag;
   endfunction

   function automatic int quad_dx(input logic [1:0] v, input int mag);
      return sgn_mag(QUAD_SX[v], mag);
   endfunction

   function automatic int quad_dy(input logic [1:0] v, input int mag);
      return sgn_mag(QUAD_SY[v], mag);
   endfunction

endpackage

// File: rtl/car_trig_lut.sv
// Quarter-wave sine table with quadrant folding; sin/cos registered one cycle after the angle.
module car_trig_lut
   import car_geom_pkg::*;
#(
   parameter int ANGLE_BITS = 10
) (
   input  logic                         clk_i,
   input  logic [ANGLE_BITS-1:0]        angle_i,
   output logic signed [TRIG_W-1:0]     sin_o,
   output logic signed [TRIG_W-1:0]     cos_o
);

   localparam int     QB     = ANGLE_BITS - 2;
   localparam int     QN     = 1 << QB;
   localparam longint PI_Q30 = 64'sd3373259426;

   // Elaboration-time round(2^TRIG_FRAC * sin(pi*k/(2*QN))) via a Q30 Taylor series.
   function automatic logic [TRIG_W-2:0] qsin(input int k);
      longint x, x2, term, acc;
      x    = (PI_Q30 * longint'(k)) / longint'(2 * QN);
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int n = 1; n <= 10; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
         acc  = acc + term;
      end
      return (TRIG_W-1)'(((acc << TRIG_FRAC) + (64'sd1 <<< 29)) >>> 30);
   endfunction

   logic [TRIG_W-2:0] qtab [QN+1];

   for (genvar k = 0; k <= QN; k++) begin : g_tab
      localparam logic [TRIG_W-2:0] QV = qsin(k);
      assign qtab[k] = QV;
   end

   logic [1:0]              quad;
   logic [QB:0]             i_fwd, i_rev;
   logic signed [TRIG_W-1:0] t_fwd, t_rev;

   assign quad  = angle_i[ANGLE_BITS-1 -: 2];
   assign i_fwd = {1'b0, angle_i[QB-1:0]};
   assign i_rev = (QB+1)'(QN) - i_fwd;
   assign t_fwd = signed'({1'b0, qtab[i_fwd]});
   assign t_rev = signed'({1'b0, qtab[i_rev]});

   // Fold the quadrant: cos(a) is sin(a + quarter turn).
   always_ff @(posedge clk_i) begin
      case (quad)
         2'd0: begin
            sin_o <= t_fwd;
            cos_o <= t_rev;
         end
         2'd1: begin
            sin_o <= t_rev;
            cos_o <= -t_fwd;
         end
         2'd2: begin
            sin_o <= -t_fwd;
            cos_o <= -t_rev;
         end
         default: begin
            sin_o <= -t_rev;
            cos_o <= t_fwd;
         end
      endcase
   end

endmodule

// File: rtl/car_vertex_gen.sv
// Per-frame car geometry: rotates body and wheel quads into world space, one vertex per cycle,
// into shadow registers, then commits all 24 coordinates at once.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for start_in; outputs hold last pose
// ST_TRIG   | angles latched, trig LUTs settling
// ST_BODY   | body vertices 0..3 (step_q)
// ST_WCTR   | wheel centres 1, 2 (step_q)
// ST_WHEEL  | wheel 1 v0..v3 then wheel 2 v0..v3 (step_q)
// ST_COMMIT | shadow copied to outputs, done pulse
module car_vertex_gen
   import car_geom_pkg::*;
#(
   parameter int WORLD_BITS = 18,
   parameter int ANGLE_BITS = 10,
   parameter int RESET_X    = 600,
   parameter int RESET_Y    = 350
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         start_in,
   input  logic signed [WORLD_BITS-1:0] center_x_in,
   input  logic signed [WORLD_BITS-1:0] center_y_in,
   input  logic [ANGLE_BITS-1:0]        body_angle_in,
   input  logic [ANGLE_BITS-1:0]        wheel_angle_in,
   output logic signed [WORLD_BITS-1:0] car_body_xs_out [4],
   output logic signed [WORLD_BITS-1:0] car_body_ys_out [4],
   output logic signed [WORLD_BITS-1:0] car_wheel_1_xs_out [4],
   output logic signed [WORLD_BITS-1:0] car_wheel_1_ys_out [4],
   output logic signed [WORLD_BITS-1:0] car_wheel_2_xs_out [4],
   output logic signed [WORLD_BITS-1:0] car_wheel_2_ys_out [4],
   output logic                         busy_out,
   output logic                         done_out
);

   localparam int SW = WORLD_BITS + TRIG_W + 1;

   typedef logic signed [WORLD_BITS-1:0] coord_t;

   state_e state_q, state_d;
   logic [2:0] step_q, step_d;
   logic done_q, done_d;
   logic latch_en, commit_en;

   coord_t cx_q, cy_q;
   logic [ANGLE_BITS-1:0] ang_b_q, ang_w_q, ang_wheel;

   logic signed [TRIG_W-1:0] sin_b, cos_b, sin_w, cos_w, sin_sel, cos_sel;
   coord_t dx, dy, base_x, base_y, new_x, new_y;
   logic signed [SW-1:0] sum_x, sum_y;
   logic unused_sum;

   coord_t sh_bx_q [4], sh_by_q [4];
   coord_t sh_w1x_q [4], sh_w1y_q [4];
   coord_t sh_w2x_q [4], sh_w2y_q [4];
   coord_t wc_x_q [2], wc_y_q [2];

   assign ang_wheel = ang_b_q + ang_w_q;

   car_trig_lut #(.ANGLE_BITS(ANGLE_BITS)) u_trig_body (
      .clk_i   (clk_in),
      .angle_i (ang_b_q),
      .sin_o   (sin_b),
      .cos_o   (cos_b)
   );

   car_trig_lut #(.ANGLE_BITS(ANGLE_BITS)) u_trig_wheel (
      .clk_i   (clk_in),
      .angle_i (ang_wheel),
      .sin_o   (sin_w),
      .cos_o   (cos_w)
   );

   // State register; reset aborts any frame in flight without a done pulse.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         done_q  <= done_d;
      end
   end

   // Fixed 16-cycle schedule; start_in is only honoured in ST_IDLE.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      done_d    = 1'b0;
      latch_en  = 1'b0;
      commit_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_in) begin
               latch_en = 1'b1;
               state_d  = ST_TRIG;
            end
         end
         ST_TRIG: begin
            step_d  = '0;
            state_d = ST_BODY;
         end
         ST_BODY: begin
            step_d = step_q + 3'd1;
            if (step_q == 3'd3) begin
               step_d  = '0;
               state_d = ST_WCTR;
            end
         end
         ST_WCTR: begin
            step_d = step_q + 3'd1;
            if (step_q == 3'd1) begin
               step_d  = '0;
               state_d = ST_WHEEL;
            end
         end
         ST_WHEEL: begin
            step_d = step_q + 3'd1;
            if (step_q == 3'd7) begin
               step_d  = '0;
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            commit_en = 1'b1;
            done_d    = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Capture the pose at start so later input changes cannot tear the frame.
   always_ff @(posedge clk_in) begin
      if (latch_en) begin
         cx_q    <= center_x_in;
         cy_q    <= center_y_in;
         ang_b_q <= body_angle_in;
         ang_w_q <= wheel_angle_in;
      end
   end

   // Select offset, rotation and base point for the vertex computed this step.
   always_comb begin
      dx      = '0;
      dy      = '0;
      base_x  = cx_q;
      base_y  = cy_q;
      sin_sel = sin_b;
      cos_sel = cos_b;
      case (state_q)
         ST_BODY: begin
            dx = WORLD_BITS'(quad_dx(step_q[1:0], BODY_HX));
            dy = WORLD_BITS'(quad_dy(step_q[1:0], BODY_HY));
         end
         ST_WCTR: begin
            dx = WORLD_BITS'(sgn_mag(step_q[0], WHEEL_OX));
            dy = WORLD_BITS'(WHEEL_OY);
         end
         ST_WHEEL: begin
            dx      = WORLD_BITS'(quad_dx(step_q[1:0], WHEEL_H));
            dy      = WORLD_BITS'(quad_dy(step_q[1:0], WHEEL_H));
            base_x  = wc_x_q[step_q[2]];
            base_y  = wc_y_q[step_q[2]];
            sin_sel = sin_w;
            cos_sel = cos_w;
         end
         default: ;
      endcase
   end

   // Four signed multiplies, round-half-up, then wrap-add onto the base point.
   assign sum_x = SW'(dx) * SW'(cos_sel) - SW'(dy) * SW'(sin_sel) + SW'(ROUND_HALF);
   assign sum_y = SW'(dx) * SW'(sin_sel) + SW'(dy) * SW'(cos_sel) + SW'(ROUND_HALF);
   assign new_x = base_x + sum_x[TRIG_FRAC +: WORLD_BITS];
   assign new_y = base_y + sum_y[TRIG_FRAC +: WORLD_BITS];
   assign unused_sum = ^{sum_x[TRIG_FRAC-1:0], sum_x[SW-1:TRIG_FRAC+WORLD_BITS],
                         sum_y[TRIG_FRAC-1:0], sum_y[SW-1:TRIG_FRAC+WORLD_BITS]};

   // Shadow and wheel-centre registers, written one vertex per step.
   always_ff @(posedge clk_in) begin
      case (state_q)
         ST_BODY: begin
            sh_bx_q[step_q[1:0]] <= new_x;
            sh_by_q[step_q[1:0]] <= new_y;
         end
         ST_WCTR: begin
            wc_x_q[step_q[0]] <= new_x;
            wc_y_q[step_q[0]] <= new_y;
         end
         ST_WHEEL: begin
            if (step_q[2]) begin
               sh_w2x_q[step_q[1:0]] <= new_x;
               sh_w2y_q[step_q[1:0]] <= new_y;
            end else begin
               sh_w1x_q[step_q[1:0]] <= new_x;
               sh_w1y_q[step_q[1:0]] <= new_y;
            end
         end
         default: ;
      endcase
   end

   // Output registers: angle-0 pose at (RESET_X, RESET_Y) on reset, full shadow on commit.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int v = 0; v < 4; v++) begin
            car_body_xs_out[v]    <= WORLD_BITS'(RESET_X + quad_dx(2'(v), BODY_HX));
            car_body_ys_out[v]    <= WORLD_BITS'(RESET_Y + quad_dy(2'(v), BODY_HY));
            car_wheel_1_xs_out[v] <= WORLD_BITS'(RESET_X - WHEEL_OX + quad_dx(2'(v), WHEEL_H));
            car_wheel_1_ys_out[v] <= WORLD_BITS'(RESET_Y + WHEEL_OY + quad_dy(2'(v), WHEEL_H));
            car_wheel_2_xs_out[v] <= WORLD_BITS'(RESET_X + WHEEL_OX + quad_dx(2'(v), WHEEL_H));
            car_wheel_2_ys_out[v] <= WORLD_BITS'(RESET_Y + WHEEL_OY + quad_dy(2'(v), WHEEL_H));
         end
      end else if (commit_en) begin
         car_body_xs_out    <= sh_bx_q;
         car_body_ys_out    <= sh_by_q;
         car_wheel_1_xs_out <= sh_w1x_q;
         car_wheel_1_ys_out <= sh_w1y_q;
         car_wheel_2_xs_out <= sh_w2x_q;
         car_wheel_2_ys_out <= sh_w2y_q;
      end
   end

   assign busy_out = (state_q != ST_IDLE);
   assign done_out = done_q;

endmodule

// File: tb/tb_car_vertex_gen.sv
// Self-checking bench for car_vertex_gen: hand-derived vector table, corner sequences and
// randomized frames against a real-arithmetic reference model.
module tb_car_vertex_gen;

   logic clk = 1'b0;
   logic rst_in, start_in;
   logic signed [17:0] center_x_in, center_y_in;
   logic [9:0] body_angle_in, wheel_angle_in;
   logic signed [17:0] car_body_xs_out [4];
   logic signed [17:0] car_body_ys_out [4];
   logic signed [17:0] car_wheel_1_xs_out [4];
   logic signed [17:0] car_wheel_1_ys_out [4];
   logic signed [17:0] car_wheel_2_xs_out [4];
   logic signed [17:0] car_wheel_2_ys_out [4];
   logic busy_out, done_out;

   car_vertex_gen dut (
      .clk_in             (clk),
      .rst_in             (rst_in),
      .start_in           (start_in),
      .center_x_in        (center_x_in),
      .center_y_in        (center_y_in),
      .body_angle_in      (body_angle_in),
      .wheel_angle_in     (wheel_angle_in),
      .car_body_xs_out    (car_body_xs_out),
      .car_body_ys_out    (car_body_ys_out),
      .car_wheel_1_xs_out (car_wheel_1_xs_out),
      .car_wheel_1_ys_out (car_wheel_1_ys_out),
      .car_wheel_2_xs_out (car_wheel_2_xs_out),
      .car_wheel_2_ys_out (car_wheel_2_ys_out),
      .busy_out           (busy_out),
      .done_out           (done_out)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int done_pulses = 0;

   always @(negedge clk) if (done_out) done_pulses++;

   // Quad q (0 body, 1 wheel 1, 2 wheel 2), vertex v lives at index q*4+v.
   int exp_x [12];
   int exp_y [12];
   int got_x [12];
   int got_y [12];
   int rst_x [12] = '{500, 500, 700, 700, 475, 475, 525, 525, 675, 675, 725, 725};
   int rst_y [12] = '{300, 400, 400, 300, 275, 325, 325, 275, 275, 325, 325, 275};

   typedef struct {
      int cx, cy, ab, aw;
      int bx0, by0, bx2, by2, w1x0, w1y0, w2x2, w2y2;
   } vec_t;
   vec_t vecs [6];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int tsin(input int a);
      real pi = 3.14159265358979323846;
      return int'(16384.0 * $sin(2.0 * pi * real'(a % 1024) / 1024.0));
   endfunction

   function automatic int wrap18(input longint v);
      logic signed [17:0] t;
      t = 18'(v);
      return int'(t);
   endfunction

   function automatic int rot_x(input int dx, input int dy, input int a);
      longint s, c;
      s = longint'(tsin(a));
      c = longint'(tsin(a + 256));
      return int'((longint'(dx) * c - longint'(dy) * s + 64'sd8192) >>> 14);
   endfunction

   function automatic int rot_y(input int dx, input int dy, input int a);
      longint s, c;
      s = longint'(tsin(a));
      c = longint'(tsin(a + 256));
      return int'((longint'(dx) * s + longint'(dy) * c + 64'sd8192) >>> 14);
   endfunction

   task automatic model(input int cx, input int cy, input int ab, input int aw);
      int sx [4] = '{-1, -1, 1, 1};
      int sy [4] = '{-1, 1, 1, -1};
      int wa, wcx, wcy, off;
      wa = (ab + aw) % 1024;
      for (int v = 0; v < 4; v++) begin
         exp_x[v] = wrap18(longint'(cx) + rot_x(100 * sx[v], 50 * sy[v], ab));
         exp_y[v] = wrap18(longint'(cy) + rot_y(100 * sx[v], 50 * sy[v], ab));
      end
      for (int w = 0; w < 2; w++) begin
         off = (w == 0) ? -100 : 100;
         wcx = wrap18(longint'(cx) + rot_x(off, -50, ab));
         wcy = wrap18(longint'(cy) + rot_y(off, -50, ab));
         for (int v = 0; v < 4; v++) begin
            exp_x[4 + 4 * w + v] = wrap18(longint'(wcx) + rot_x(25 * sx[v], 25 * sy[v], wa));
            exp_y[4 + 4 * w + v] = wrap18(longint'(wcy) + rot_y(25 * sx[v], 25 * sy[v], wa));
         end
      end
   endtask

   // ---------------- DUT access ----------------
   task automatic get_pose();
      for (int v = 0; v < 4; v++) begin
         got_x[v]     = car_body_xs_out[v];
         got_y[v]     = car_body_ys_out[v];
         got_x[4 + v] = car_wheel_1_xs_out[v];
         got_y[4 + v] = car_wheel_1_ys_out[v];
         got_x[8 + v] = car_wheel_2_xs_out[v];
         got_y[8 + v] = car_wheel_2_ys_out[v];
      end
   endtask

   task automatic check_model_pose(input string tag);
      get_pose();
      for (int i = 0; i < 12; i++) begin
         check($sformatf("%s_x%0d", tag, i), got_x[i], exp_x[i]);
         check($sformatf("%s_y%0d", tag, i), got_y[i], exp_y[i]);
      end
   endtask

   task automatic check_reset_pose(input string tag);
      get_pose();
      for (int i = 0; i < 12; i++) begin
         check($sformatf("%s_x%0d", tag, i), got_x[i], rst_x[i]);
         check($sformatf("%s_y%0d", tag, i), got_y[i], rst_y[i]);
      end
   endtask

   // One frame over a bounded 40-cycle window. Inputs are scrambled after the start edge;
   // optional second start pulse / reset pulse land on the given edge numbers.
   task automatic frame(input int cx, input int cy, input int ab, input int aw,
                        input int restart_at, input int reset_at,
                        output int seen, output int lat);
      @(negedge clk);
      center_x_in    = 18'(cx);
      center_y_in    = 18'(cy);
      body_angle_in  = 10'(ab);
      wheel_angle_in = 10'(aw);
      start_in       = 1'b1;
      seen = 0;
      lat  = -1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         start_in = (cyc == restart_at);
         rst_in   = (cyc == reset_at);
         if (cyc == 3) begin
            center_x_in    = ~center_x_in;
            center_y_in    = center_y_in + 18'sd77;
            body_angle_in  = body_angle_in + 10'd3;
            wheel_angle_in = ~wheel_angle_in;
         end
         if (cyc == 2) check("busy_mid_frame", int'(busy_out), 1);
         if (done_out) begin
            seen++;
            if (lat < 0) begin
               lat = cyc - 1;
               check("busy_at_done", int'(busy_out), 0);
            end
         end
      end
      start_in = 1'b0;
      rst_in   = 1'b0;
   endtask

   int seen, lat, base;
   int cx, cy, ab, aw;

   initial begin
      //                 cx      cy   ab   aw   bx0     by0  bx2      by2  w1x0    w1y0  w2x2     w2y2
      vecs[0] = '{  1000, -200,   0,   0,     900, -250,    1100, -150,    875, -275,    1125, -225};
      vecs[1] = '{     0,    0, 256,   0,      50, -100,     -50,  100,     75, -125,      25,  125};
      vecs[2] = '{   600,  350,   0, 256,     500,  300,     700,  400,    525,  275,     675,  325};
      vecs[3] = '{131071,    0,   0,   0,  130971,  -50, -130973,   50, 130946,  -75, -130948,  -25};
      vecs[4] = '{  -300,  400, 512, 512,    -200,  450,    -400,  350,   -225,  425,    -375,  475};
      vecs[5] = '{     0,    0, 768,   0,     -50,  100,      50, -100,    -75,  125,     -25, -125};

      rst_in = 1'b1;
      start_in = 1'b0;
      center_x_in = '0;
      center_y_in = '0;
      body_angle_in = '0;
      wheel_angle_in = '0;
      repeat (3) @(negedge clk);
      rst_in = 1'b0;

      // Reset state, then idle without start.
      check_reset_pose("reset");
      check("reset_busy", int'(busy_out), 0);
      check("reset_done", int'(done_out), 0);
      repeat (20) @(negedge clk);
      check("idle_no_done", done_pulses, 0);
      check("idle_busy", int'(busy_out), 0);

      // Hand-derived vector table.
      for (int i = 0; i < 6; i++) begin
         frame(vecs[i].cx, vecs[i].cy, vecs[i].ab, vecs[i].aw, 0, 0, seen, lat);
         check($sformatf("vec%0d_done_count", i), seen, 1);
         check($sformatf("vec%0d_latency", i), lat, 16);
         get_pose();
         check($sformatf("vec%0d_bx0", i), got_x[0], vecs[i].bx0);
         check($sformatf("vec%0d_by0", i), got_y[0], vecs[i].by0);
         check($sformatf("vec%0d_bx2", i), got_x[2], vecs[i].bx2);
         check($sformatf("vec%0d_by2", i), got_y[2], vecs[i].by2);
         check($sformatf("vec%0d_w1x0", i), got_x[4], vecs[i].w1x0);
         check($sformatf("vec%0d_w1y0", i), got_y[4], vecs[i].w1y0);
         check($sformatf("vec%0d_w2x2", i), got_x[10], vecs[i].w2x2);
         check($sformatf("vec%0d_w2y2", i), got_y[10], vecs[i].w2y2);
      end

      // Wrap case: every coordinate against the model too.
      model(131071, 0, 0, 0);
      frame(131071, 0, 0, 0, 0, 0, seen, lat);
      check_model_pose("wrap");

      // Second start while busy is ignored.
      frame(1234, -567, 100, 300, 5, 0, seen, lat);
      check("restart_done_count", seen, 1);
      check("restart_latency", lat, 16);
      model(1234, -567, 100, 300);
      check_model_pose("restart");

      // Reset on edge 9 of a run: reset pose, no done.
      frame(-2000, 3000, 700, 50, 0, 9, seen, lat);
      check("midreset_done_count", seen, 0);
      check("midreset_busy", int'(busy_out), 0);
      check_reset_pose("midreset");

      // Next start after the abort completes normally.
      frame(-2000, 3000, 700, 50, 0, 0, seen, lat);
      check("post_reset_done_count", seen, 1);
      check("post_reset_latency", lat, 16);
      model(-2000, 3000, 700, 50);
      check_model_pose("post_reset");

      // Reset and start on the same edge: reset wins.
      @(negedge clk);
      center_x_in = 18'sd4321;
      body_angle_in = 10'd123;
      rst_in = 1'b1;
      start_in = 1'b1;
      @(negedge clk);
      rst_in = 1'b0;
      start_in = 1'b0;
      check("rst_start_busy", int'(busy_out), 0);
      base = done_pulses;
      repeat (24) @(negedge clk);
      check("rst_start_no_done", done_pulses - base, 0);
      check_reset_pose("rst_start");

      // Randomized frames.
      for (int r = 0; r < 20; r++) begin
         cx = int'($urandom_range(0, 262143)) - 131072;
         cy = int'($urandom_range(0, 262143)) - 131072;
         ab = int'($urandom_range(0, 1023));
         aw = int'($urandom_range(0, 1023));
         model(cx, cy, ab, aw);
         frame(cx, cy, ab, aw, 0, 0, seen, lat);
         check($sformatf("rand%0d_done_count", r), seen, 1);
         check($sformatf("rand%0d_latency", r), lat, 16);
         check_model_pose($sformatf("rand%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
